// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported SRAM between instruction fetch and the data stage.
// Every access holds the port for SRAM_WAIT cycles, then spends one DONE cycle pulsing done/gnt.
// Backpressure: requesters hold their request and see a combinational stall until their done/gnt.
module mem_port_arbiter #(
    parameter int unsigned SRAM_WAIT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        sram_en,
    output logic        sram_we,
    output logic [29:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_MEM,
        SERVE_IF,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic        wr_q;
    logic        kill_q;
    logic        mem_go;
    logic        last;
    logic        serving;
    logic        unused_addr_lsbs;

    // Byte-offset bits are irrelevant to a word-wide SRAM.
    assign unused_addr_lsbs = ^{mem_addr[1:0], if_addr[1:0]};

    assign mem_go  = mem_rd | mem_wr;
    assign last    = (cnt == 4'(SRAM_WAIT - 1));
    assign serving = (state == SERVE_MEM) || (state == SERVE_IF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_go) begin
                    state_nxt = SERVE_MEM;
                end else if (if_req) begin
                    state_nxt = SERVE_IF;
                end
            end
            SERVE_MEM, SERVE_IF: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            kill_q    <= 1'b0;
            if_gnt    <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if_gnt   <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (mem_go) begin
                        addr_q  <= mem_addr[31:2];
                        wdata_q <= mem_wdata;
                        wr_q    <= mem_wr;
                        kill_q  <= 1'b0;
                    end else if (if_req) begin
                        addr_q <= if_addr[31:2];
                        wr_q   <= 1'b0;
                        kill_q <= if_flush;
                    end
                end
                SERVE_MEM: begin
                    cnt <= cnt + 4'd1;
                    if (last) begin
                        mem_done <= 1'b1;
                        if (!wr_q) begin
                            mem_rdata <= sram_rdata;
                        end
                    end
                end
                SERVE_IF: begin
                    cnt <= cnt + 4'd1;
                    if (if_flush) begin
                        kill_q <= 1'b1;
                    end
                    // A flush on the final cycle still has to kill this fetch.
                    if (last && !(kill_q || if_flush)) begin
                        if_gnt   <= 1'b1;
                        if_rdata <= sram_rdata;
                    end
                end
                DONE: begin
                    cnt    <= '0;
                    kill_q <= 1'b0;
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign sram_en    = serving;
    assign sram_addr  = serving ? addr_q : '0;
    assign sram_we    = (state == SERVE_MEM) && wr_q;
    assign sram_wdata = (state == SERVE_MEM) ? wdata_q : '0;

    assign mem_stall = mem_go & ~mem_done;
    assign if_stall  = if_req & ~if_gnt;

endmodule
